// File: rtl/sd_emmc_fifo_filler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sd_emmc_fifo_filler_if : serializer / DMA side signals of the word buffer
// Revision: 1.0
// ----------------------------------------------------------------------------
interface sd_emmc_fifo_filler_if #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 7
);
  logic                  fifo_rst;
  logic                  ser_wr_en;
  logic [DATA_W-1:0]     ser_wr_data;
  logic                  is_we_en;
  logic                  dma_rd_ready;
  logic [DATA_W-1:0]     axi_wdata;
  logic [DEPTH_LOG2:0]   rx_count;
  logic                  rx_empty;
  logic                  rx_full;
  logic                  rx_overflow;
  logic [DATA_W-1:0]     axi_rdata;
  logic                  dma_wr_ready;
  logic                  ser_rd_en;
  logic [DATA_W-1:0]     ser_rd_data;
  logic [DEPTH_LOG2:0]   tx_count;
  logic                  tx_empty;
  logic                  tx_full;
  logic                  tx_underrun;

  modport master (
    output fifo_rst, ser_wr_en, ser_wr_data, dma_rd_ready, axi_rdata,
           dma_wr_ready, ser_rd_en,
    input  is_we_en, axi_wdata, rx_count, rx_empty, rx_full, rx_overflow,
           ser_rd_data, tx_count, tx_empty, tx_full, tx_underrun
  );

  modport slave (
    input  fifo_rst, ser_wr_en, ser_wr_data, dma_rd_ready, axi_rdata,
           dma_wr_ready, ser_rd_en,
    output is_we_en, axi_wdata, rx_count, rx_empty, rx_full, rx_overflow,
           ser_rd_data, tx_count, tx_empty, tx_full, tx_underrun
  );
endinterface
`default_nettype wire

// File: rtl/sd_emmc_fifo_filler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sd_emmc_fifo_filler : RX/TX word FIFOs between the SD/eMMC serializer and DMA
// Revision: 1.0
// ----------------------------------------------------------------------------
module sd_emmc_fifo_filler #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                    clock,
  input  logic                    reset,
  sd_emmc_fifo_filler_if.slave    bus
);

  localparam int                  c_DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] c_CNT_ZERO = '0;
  localparam logic [DEPTH_LOG2:0] c_CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // RX path state
  logic [DATA_W-1:0]     r_rx_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_rx_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rx_rd_ptr;
  logic [DEPTH_LOG2:0]   r_rx_count;
  logic                  r_rx_overflow;
  logic                  r_is_we_en;
  logic                  r_dma_rd_ready_q;

  // TX path state
  logic [DATA_W-1:0]     r_tx_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_tx_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_tx_rd_ptr;
  logic [DEPTH_LOG2:0]   r_tx_count;
  logic                  r_tx_underrun;
  logic                  r_dma_wr_ready_q;

  logic w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;

  assign w_rx_full  = (r_rx_count == c_CNT_FULL);
  assign w_rx_empty = (r_rx_count == c_CNT_ZERO);
  assign w_tx_full  = (r_tx_count == c_CNT_FULL);
  assign w_tx_empty = (r_tx_count == c_CNT_ZERO);

  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign w_rx_pop  = bus.dma_rd_ready & ~r_dma_rd_ready_q & ~w_rx_empty;
  assign w_rx_push = bus.ser_wr_en & (~w_rx_full | w_rx_pop);
  assign w_tx_pop  = bus.ser_rd_en & ~w_tx_empty;
  assign w_tx_push = bus.dma_wr_ready & ~r_dma_wr_ready_q & (~w_tx_full | w_tx_pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rx_wr_ptr      <= '0;
      r_rx_rd_ptr      <= '0;
      r_rx_count       <= '0;
      r_rx_overflow    <= 1'b0;
      r_is_we_en       <= 1'b0;
      r_dma_rd_ready_q <= 1'b0;
    end else begin
      r_dma_rd_ready_q <= bus.dma_rd_ready;
      if (bus.fifo_rst) begin
        r_rx_wr_ptr   <= '0;
        r_rx_rd_ptr   <= '0;
        r_rx_count    <= '0;
        r_rx_overflow <= 1'b0;
        r_is_we_en    <= 1'b0;
      end else begin
        r_is_we_en <= w_rx_push;
        if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + c_PTR_ONE;
        if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + c_PTR_ONE;
        if (w_rx_push && !w_rx_pop)
          r_rx_count <= r_rx_count + c_CNT_ONE;
        else if (w_rx_pop && !w_rx_push)
          r_rx_count <= r_rx_count - c_CNT_ONE;
        if (bus.ser_wr_en && !w_rx_push) r_rx_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tx_wr_ptr      <= '0;
      r_tx_rd_ptr      <= '0;
      r_tx_count       <= '0;
      r_tx_underrun    <= 1'b0;
      r_dma_wr_ready_q <= 1'b0;
    end else begin
      r_dma_wr_ready_q <= bus.dma_wr_ready;
      if (bus.fifo_rst) begin
        r_tx_wr_ptr   <= '0;
        r_tx_rd_ptr   <= '0;
        r_tx_count    <= '0;
        r_tx_underrun <= 1'b0;
      end else begin
        if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + c_PTR_ONE;
        if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + c_PTR_ONE;
        if (w_tx_push && !w_tx_pop)
          r_tx_count <= r_tx_count + c_CNT_ONE;
        else if (w_tx_pop && !w_tx_push)
          r_tx_count <= r_tx_count - c_CNT_ONE;
        if (bus.ser_rd_en && w_tx_empty) r_tx_underrun <= 1'b1;
      end
    end
  end

  // Storage arrays are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (reset && !bus.fifo_rst && w_rx_push) r_rx_mem[r_rx_wr_ptr] <= bus.ser_wr_data;
    if (reset && !bus.fifo_rst && w_tx_push) r_tx_mem[r_tx_wr_ptr] <= bus.axi_rdata;
  end

  assign bus.is_we_en    = r_is_we_en;
  assign bus.axi_wdata   = r_rx_mem[r_rx_rd_ptr];
  assign bus.rx_count    = r_rx_count;
  assign bus.rx_empty    = w_rx_empty;
  assign bus.rx_full     = w_rx_full;
  assign bus.rx_overflow = r_rx_overflow;
  assign bus.ser_rd_data = r_tx_mem[r_tx_rd_ptr];
  assign bus.tx_count    = r_tx_count;
  assign bus.tx_empty    = w_tx_empty;
  assign bus.tx_full     = w_tx_full;
  assign bus.tx_underrun = r_tx_underrun;

endmodule
`default_nettype wire

// File: tb/tb_sd_emmc_fifo_filler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sd_emmc_fifo_filler : directed self-checking bench for sd_emmc_fifo_filler
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_sd_emmc_fifo_filler;

  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 7;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  sd_emmc_fifo_filler_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  sd_emmc_fifo_filler #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One DMA pulse: a high cycle followed by a low cycle.
  task automatic rx_pop_pulse();
    bus.dma_rd_ready = 1'b1;
    tick();
    bus.dma_rd_ready = 1'b0;
    tick();
  endtask

  task automatic tx_push_pulse(input logic [31:0] word);
    bus.axi_rdata    = word;
    bus.dma_wr_ready = 1'b1;
    tick();
    bus.dma_wr_ready = 1'b0;
    bus.axi_rdata    = 32'hDEAD_BEEF;
    tick();
  endtask

  task automatic rx_write(input logic [31:0] word);
    bus.ser_wr_en   = 1'b1;
    bus.ser_wr_data = word;
    tick();
    bus.ser_wr_en   = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset            = 1'b0;
    bus.fifo_rst     = 1'b0;
    bus.ser_wr_en    = 1'b0;
    bus.ser_wr_data  = '0;
    bus.dma_rd_ready = 1'b0;
    bus.axi_rdata    = '0;
    bus.dma_wr_ready = 1'b0;
    bus.ser_rd_en    = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    chk("reset_rx_count", 32'(bus.rx_count), 32'd0);
    chk("reset_tx_count", 32'(bus.tx_count), 32'd0);
    chk("reset_rx_empty", 32'(bus.rx_empty), 32'd1);
    chk("reset_tx_empty", 32'(bus.tx_empty), 32'd1);
    chk("reset_rx_full", 32'(bus.rx_full), 32'd0);
    chk("reset_tx_full", 32'(bus.tx_full), 32'd0);
    chk("reset_rx_overflow", 32'(bus.rx_overflow), 32'd0);
    chk("reset_tx_underrun", 32'(bus.tx_underrun), 32'd0);
    chk("reset_is_we_en", 32'(bus.is_we_en), 32'd0);

    // Fill RX with 0x00..0x7F at one word per cycle.
    for (int i = 0; i < 128; i++) begin
      bus.ser_wr_en   = 1'b1;
      bus.ser_wr_data = 32'(i);
      tick();
      if (i == 0) begin
        chk("rx_first_head", bus.axi_wdata, 32'h0);
        chk("rx_first_not_empty", 32'(bus.rx_empty), 32'd0);
        chk("rx_first_we_en", 32'(bus.is_we_en), 32'd1);
      end
    end
    chk("rx_full_count", 32'(bus.rx_count), 32'd128);
    chk("rx_full_flag", 32'(bus.rx_full), 32'd1);
    chk("rx_full_no_ovf", 32'(bus.rx_overflow), 32'd0);
    bus.ser_wr_data = 32'hAA;
    tick();
    bus.ser_wr_en = 1'b0;
    chk("rx_ovf_set", 32'(bus.rx_overflow), 32'd1);
    chk("rx_ovf_count", 32'(bus.rx_count), 32'd128);
    chk("rx_ovf_no_we_en", 32'(bus.is_we_en), 32'd0);
    chk("rx_ovf_head", bus.axi_wdata, 32'h0);

    for (int i = 0; i < 128; i++) begin
      chk("rx_drain_head", bus.axi_wdata, 32'(i));
      rx_pop_pulse();
    end
    chk("rx_drain_empty", 32'(bus.rx_empty), 32'd1);
    chk("rx_drain_count", 32'(bus.rx_count), 32'd0);
    chk("rx_ovf_sticky", 32'(bus.rx_overflow), 32'd1);

    // A pop on an empty RX is ignored.
    rx_pop_pulse();
    chk("rx_empty_pop_count", 32'(bus.rx_count), 32'd0);

    // Level held for 10 cycles gives a single pop.
    for (int i = 0; i < 5; i++) rx_write(32'h10 + 32'(i));
    chk("rx_hold_pre_count", 32'(bus.rx_count), 32'd5);
    bus.dma_rd_ready = 1'b1;
    repeat (10) tick();
    bus.dma_rd_ready = 1'b0;
    tick();
    chk("rx_hold_count", 32'(bus.rx_count), 32'd4);
    chk("rx_hold_head", bus.axi_wdata, 32'h11);

    bus.fifo_rst = 1'b1;
    tick();
    bus.fifo_rst = 1'b0;
    chk("rx_clr_count", 32'(bus.rx_count), 32'd0);
    chk("rx_clr_ovf", 32'(bus.rx_overflow), 32'd0);

    // Simultaneous push and pop at full, with the write pointer wrapping.
    for (int i = 0; i < 128; i++) rx_write(32'h200 + 32'(i));
    chk("rx_wrap_full", 32'(bus.rx_full), 32'd1);
    bus.ser_wr_en    = 1'b1;
    bus.ser_wr_data  = 32'h999;
    bus.dma_rd_ready = 1'b1;
    tick();
    bus.ser_wr_en    = 1'b0;
    bus.dma_rd_ready = 1'b0;
    chk("rx_both_count", 32'(bus.rx_count), 32'd128);
    chk("rx_both_no_ovf", 32'(bus.rx_overflow), 32'd0);
    chk("rx_both_we_en", 32'(bus.is_we_en), 32'd1);
    chk("rx_both_head", bus.axi_wdata, 32'h201);
    tick();
    for (int i = 1; i < 128; i++) begin
      chk("rx_wrap_head", bus.axi_wdata, 32'h200 + 32'(i));
      rx_pop_pulse();
    end
    chk("rx_wrap_last", bus.axi_wdata, 32'h999);
    rx_pop_pulse();
    chk("rx_wrap_empty", 32'(bus.rx_empty), 32'd1);

    // TX: three DMA pushes, four serializer pops.
    tx_push_pulse(32'hA000_000A);
    tx_push_pulse(32'hB000_000B);
    tx_push_pulse(32'hC000_000C);
    chk("tx_count3", 32'(bus.tx_count), 32'd3);
    chk("tx_head_a", bus.ser_rd_data, 32'hA000_000A);
    bus.ser_rd_en = 1'b1;
    tick();
    chk("tx_head_b", bus.ser_rd_data, 32'hB000_000B);
    tick();
    chk("tx_head_c", bus.ser_rd_data, 32'hC000_000C);
    tick();
    chk("tx_empty_after3", 32'(bus.tx_empty), 32'd1);
    chk("tx_no_underrun_yet", 32'(bus.tx_underrun), 32'd0);
    tick();
    bus.ser_rd_en = 1'b0;
    chk("tx_underrun", 32'(bus.tx_underrun), 32'd1);
    chk("tx_underrun_count", 32'(bus.tx_count), 32'd0);

    // is_we_en follows a single accepted write by exactly one cycle.
    rx_write(32'h77);
    chk("we_en_high", 32'(bus.is_we_en), 32'd1);
    tick();
    chk("we_en_low", 32'(bus.is_we_en), 32'd0);

    // fifo_rst with RX at 50, underrun set and dma_wr_ready held high.
    for (int i = 0; i < 49; i++) rx_write(32'(i));
    chk("rst_pre_rx50", 32'(bus.rx_count), 32'd50);
    bus.axi_rdata    = 32'h1234_5678;
    bus.dma_wr_ready = 1'b1;
    tick();
    chk("rst_pre_tx1", 32'(bus.tx_count), 32'd1);
    bus.fifo_rst = 1'b1;
    tick();
    bus.fifo_rst = 1'b0;
    chk("rst_rx_count", 32'(bus.rx_count), 32'd0);
    chk("rst_tx_count", 32'(bus.tx_count), 32'd0);
    chk("rst_underrun", 32'(bus.tx_underrun), 32'd0);
    chk("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
    tick();
    chk("rst_no_tx_push", 32'(bus.tx_count), 32'd0);
    bus.dma_wr_ready = 1'b0;
    tick();

    // TX full: extra push silently dropped.
    for (int i = 0; i < 128; i++) tx_push_pulse(32'h300 + 32'(i));
    chk("tx_full_flag", 32'(bus.tx_full), 32'd1);
    tx_push_pulse(32'hFFFF);
    chk("tx_full_count", 32'(bus.tx_count), 32'd128);
    chk("tx_full_underrun", 32'(bus.tx_underrun), 32'd0);
    chk("tx_full_head", bus.ser_rd_data, 32'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
